// File: rtl/bist_response_analyzer.sv
// -----------------------------------------------------------------------------
// bist_response_analyzer
//
// Purpose:
//   BIST response stage that sits behind the registered multiplier product.
//   It gates the upstream pattern generator and drops the pipeline-fill
//   samples that come out of the multiplier output register. It then folds a
//   fixed number of products into an 8-bit MISR signature and compares that
//   signature with a golden value. The result is reported as done/pass.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset; aborts any run
//   start       in   level-sampled run request, honoured only in IDLE/DONE
//   result_in   in   [DATA_W] registered product from the multiplier
//   golden_sig  in   [DATA_W] expected signature, sampled in COMPARE
//   tpg_en      out  pattern generator enable (FLUSH, CAPTURE)
//   busy        out  run in progress (FLUSH, CAPTURE, COMPARE)
//   done        out  run complete, held until next start or rst
//   pass        out  signature matched golden_sig; meaningful while done=1
//   signature   out  [DATA_W] current MISR contents
//   sample_cnt  out  [8] products compacted in the current run
//
// Parameters:
//   DATA_W         product/signature width (MISR taps assume 8)
//   PATTERN_COUNT  products compacted per run, 1..255
//   LATENCY        pipeline-fill cycles discarded after start, 0..15
// -----------------------------------------------------------------------------
module bist_response_analyzer #(
  parameter int DATA_W        = 8,
  parameter int PATTERN_COUNT = 16,
  parameter int LATENCY       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] golden_sig,
  output logic              tpg_en,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] signature,
  output logic [7:0]        sample_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Terminal values of the two run counters. The flush counter runs from
  // 0 to LATENCY-1. The sample counter leaves CAPTURE on the edge where it
  // would reach PATTERN_COUNT.
  localparam logic [3:0] FLUSH_LAST = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);
  localparam logic [7:0] CNT_LAST   = 8'(PATTERN_COUNT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_flush_cnt;
  logic            w_run_req;

  // One MISR step for x^8+x^4+x^3+x^2+1. The feedback bit comes from taps
  // 7,5,4,3 and enters at bit 0. The incoming product is XORed over the
  // shifted word. There are no carries anywhere.
  function automatic logic [DATA_W-1:0] misr_step(
    input logic [DATA_W-1:0] sig,
    input logic [DATA_W-1:0] din
  );
    logic fb;
    fb = sig[7] ^ sig[5] ^ sig[4] ^ sig[3];
    return {sig[DATA_W-2:0], fb} ^ din;
  endfunction

  // A run request is only honoured while no run is in flight.
  assign w_run_req = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // ---- state register ------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- next state and state-decoded outputs --------------------------------
  always_comb begin
    w_state_nxt = r_state;
    tpg_en      = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = (LATENCY > 0) ? S_FLUSH : S_CAPTURE;
        end
      end
      S_FLUSH: begin
        tpg_en = 1'b1;
        busy   = 1'b1;
        if (r_flush_cnt == FLUSH_LAST) begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        tpg_en = 1'b1;
        busy   = 1'b1;
        if (sample_cnt == CNT_LAST) begin
          w_state_nxt = S_COMPARE;
        end
      end
      S_COMPARE: begin
        busy        = 1'b1;
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- run counters and result flags ---------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_cnt <= 4'd0;
      sample_cnt  <= 8'd0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      if (w_run_req) begin
        r_flush_cnt <= 4'd0;
        sample_cnt  <= 8'd0;
        done        <= 1'b0;
        pass        <= 1'b0;
      end else begin
        unique case (r_state)
          S_FLUSH: begin
            r_flush_cnt <= r_flush_cnt + 4'd1;
          end
          S_CAPTURE: begin
            sample_cnt <= sample_cnt + 8'd1;
          end
          S_COMPARE: begin
            // The signature is frozen in COMPARE, so the register itself
            // can be compared directly.
            pass <= (signature == golden_sig);
            done <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // ---- signature compaction ------------------------------------------------
  // The signature is cleared by reset and by an accepted start. It then holds
  // at zero through FLUSH, so pipeline-fill products never reach it.
  always_ff @(posedge clk) begin
    if (rst) begin
      signature <= '0;
    end else if (w_run_req) begin
      signature <= '0;
    end else if (r_state == S_CAPTURE) begin
      signature <= misr_step(signature, result_in);
    end
  end

endmodule

// File: doc/bist_response_analyzer.md
Name: bist_response_analyzer

Overview:
- Downstream BIST stage that consumes the registered 8-bit product from the radix-4 multiplier datapath.
- Compacts a fixed-length stream of products into an 8-bit MISR signature and compares it against a golden signature.
- Reports done/pass to the BIST controller.
- Drives tpg_en to gate the upstream pattern generator, and discards pipeline-fill samples produced by the multiplier's output register.

Parameters:
- DATA_W, 8, width of result_in, signature and golden_sig.
- PATTERN_COUNT, 16, number of products compacted per run; legal range 1..255.
- LATENCY, 1, cycles discarded after start to cover the multiplier output register; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  level-sampled run request; acted on only in IDLE or DONE.
- result_in  input  DATA_W  registered product from the multiplier.
- golden_sig  input  DATA_W  expected signature; sampled in COMPARE only.
- tpg_en  output  1  enables the upstream pattern generator.
- busy  output  1  high in FLUSH, CAPTURE and COMPARE.
- done  output  1  run complete; held until the next start or rst.
- pass  output  1  signature==golden_sig; valid only while done=1.
- signature  output  DATA_W  current MISR contents.
- sample_cnt  output  8  number of products compacted in the current run.

Behaviour:
- Reset: on any clk edge with rst=1, state=IDLE and tpg_en=busy=done=pass=0, signature=0, sample_cnt=0. rst overrides start and aborts a run mid-operation. No partial done/pass is produced.
- FSM states: IDLE, FLUSH, CAPTURE, COMPARE, DONE. All outputs are registered or decoded from state.
- IDLE: start=1 on an edge moves to FLUSH if LATENCY>0, else to CAPTURE. signature and sample_cnt are cleared to 0 on the same edge.
- FLUSH: an internal counter runs LATENCY cycles, then moves to CAPTURE. result_in is ignored and signature is held at 0.
- CAPTURE: on each edge, signature <= {signature[6:0], fb} ^ result_in, where fb = signature[7]^signature[5]^signature[4]^signature[3] (polynomial x^8+x^4+x^3+x^2+1). sample_cnt increments on each of these edges. On the edge where sample_cnt becomes PATTERN_COUNT, move to COMPARE.
- COMPARE: one cycle. On exit, pass <= (signature==golden_sig), done <= 1, and the FSM moves to DONE. signature is frozen.
- DONE: done, pass and signature are held.
  - start=1 restarts exactly as from IDLE: done and pass clear on that edge, signature and sample_cnt clear to 0.
- tpg_en = 1 in FLUSH and CAPTURE, 0 otherwise.
- busy = 1 in FLUSH, CAPTURE and COMPARE.
- start while busy=1 is ignored; the run is not extended or restarted.
- Timing: start sampled at edge k gives done=1 after edge k+LATENCY+PATTERN_COUNT+1. The first product compacted is the one present during the first CAPTURE cycle.
- Arithmetic: sample_cnt is modulo-256 but never exceeds PATTERN_COUNT. The signature is a pure XOR/shift; no carries.

Test Plan:
- Reset: assert rst mid-CAPTURE at cycle 5 -> next cycle state IDLE, all outputs 0; a subsequent start runs a full-length fresh run.
- Single sample (PATTERN_COUNT=1, LATENCY=0): result_in=8'h5A in the CAPTURE cycle, golden_sig=8'h5A -> signature=8'h5A, done=1 at edge k+2, pass=1. With golden_sig=8'h5B -> pass=0.
- Feedback path (PATTERN_COUNT=2, LATENCY=0): products 8'h80 then 8'h00 -> signature=8'h01. Products 8'h01 then 8'h00 -> signature=8'h02.
- Latency discard (LATENCY=1, PATTERN_COUNT=1): result_in=8'hFF during the FLUSH cycle, 8'h3C during the CAPTURE cycle -> signature=8'h3C. tpg_en is high for exactly 2 cycles.
- Start handling: pulse start during CAPTURE -> no effect on done timing. Start held in DONE -> done/pass drop next cycle and a new run begins with signature=0.
- End-to-end with the multiplier (default params): upstream LFSR feeds a/b, multiplier products go into result_in -> sample_cnt reaches 16, done after edge k+18, and signature matches the bench model. A single injected bit flip in one product -> pass=0.
